mux2_rr_arbiter: RTL
====================

# mux2_rr_arbiter

Round-robin arbiter sharing one DATA_WIDTH-bit 2:1 data mux between two requesters that present bursts to a single downstream consumer. It owns the mux select line and grants whole bursts: a burst ends on LAST, on a MAX_BURST cap, or when the owner stops requesting. The downstream side uses a valid/ready handshake. The block sits between the two bus masters and the shared result path.

## Interface
Parameters:
- DATA_WIDTH, 32, width of D0/D1/Y.
- MAX_BURST, 4, maximum accepted beats per grant; must be ≥1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- REQ0  in  1  requester 0 has a beat on D0.
- D0  in  DATA_WIDTH  requester 0 data.
- LAST0  in  1  current D0 beat is the last of its burst.
- GNT0  out  1  requester 0 beat accepted this cycle.
- REQ1, D1, LAST1, GNT1  same as above, for requester 1.
- S  out  1  mux select (0 = D0, 1 = D1); registered.
- VALID  out  1  Y carries a beat.
- Y  out  DATA_WIDTH  muxed data.
- READY  in  1  consumer accepts the beat when VALID=1.

## Operation
- States: IDLE, BUSY0, BUSY1.
- Registers:
  - state
  - S
  - ptr: last-served requester, reset 1, so requester 0 wins first.
  - cnt: accepted beats in the current burst, width $clog2(MAX_BURST+1).
- IDLE:
  - VALID=0, Y=0, GNT0=GNT1=0.
  - If any REQ is high, go to BUSYn next cycle: the sole requester, or on a tie the requester ≠ ptr.
  - Set S=n and cnt=0 on that transition.
- BUSYn:
  - VALID=REQn, Y=Dn (combinational through the mux), GNTn=VALID&READY.
  - The other GNT is 0.
  - An accepted beat increments cnt.
- Burst end, evaluated in BUSYn:
  - an accepted beat with LASTn=1; or
  - an accepted beat with cnt+1==MAX_BURST; or
  - REQn=0 (release, no beat).
- At burst end:
  - ptr←n, cnt←0.
  - Next state is chosen from the current REQs with the other requester preferred, using the updated ptr.
  - If REQm (m≠n) is high: BUSYm, S←m.
  - Else if REQn is high and this is not a release: BUSYn again, new burst.
  - Else: IDLE.
- Not at burst end with READY=0: state, S, cnt hold. Y follows Dn; the requester must hold Dn/LASTn stable while REQn=1 and GNTn=0.
- The other requester's REQ has no effect mid-burst. Starvation is bounded by MAX_BURST beats.

## Timing
- Reset (RST=0, any time, asynchronous): state=IDLE, S=0, ptr=1, cnt=0, VALID=0, Y=0, GNT0=GNT1=0 immediately.
  - A burst in progress is dropped; no GNT is emitted during reset.
- Latency: REQ rising while IDLE gives VALID=1 on the next rising edge.
  - First beat accepted in that cycle if READY=1.
- Switchover: zero bubble.
  - A final beat accepted at edge k is followed by the other requester's VALID in cycle k+1, with S already toggled.
- Throughput: 1 beat/cycle while READY=1 and REQn=1.
- GNTn is combinational, the same cycle as the handshake.
- S changes only on burst-end edges, never while VALID=1 with READY=0.
- Simultaneous LASTn and cap: a single burst end.
- MAX_BURST=1: every accepted beat ends the burst.

## Structure
- Shared package holds:
  - state encoding localparams: IDLE=2'b00, BUSY0=2'b01, BUSY1=2'b10;
  - the default DATA_WIDTH constant.
- One sub-module, arb_data_mux: DATA_WIDTH-bit 2:1 mux built by generate from the existing 1-bit 2:1 mux cell.
  - The arbiter drives its select with S.
- The FSM, ptr and cnt live in the top module.

## Test plan
- Reset/idle: RST=0 mid-burst → VALID=0, Y=0, S=0, GNTs 0 immediately. Release with no REQ → stays IDLE.
- Single requester: REQ0=1, D0=32'hA5A5_0001…0003, LAST0 on beat 3, READY=1 → VALID one cycle after REQ0, three GNT0 pulses, Y matches, then IDLE.
- Tie and fairness: REQ0=REQ1=1 from reset, LAST on every beat, READY=1 → grants alternate 0,1,0,1, S toggles each beat, no bubble cycles.
- Burst cap: REQ0 with 10-beat burst (LAST0 only on beat 10), REQ1 pending, MAX_BURST=4 → 4 GNT0 beats, then 1 REQ1 burst, then D0 beats 5–8.
- Backpressure: READY=0 for 3 cycles mid-burst → VALID=1, Y stable, S stable, GNT0=0, cnt unchanged. Resumes on READY=1 with no beat lost or duplicated.
- Release: REQ1 drops mid-burst with REQ0 high → BUSY0 next cycle, ptr=1, no GNT1 in the drop cycle.

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin burst arbiter.
package mux2_rr_arbiter_pkg;

   // Default width of the muxed data path.
   localparam int DATA_WIDTH_DEF = 32;

   // Arbiter state encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BUSY0 = 2'b01,
      BUSY1 = 2'b10
   } state_t;

endpackage

// File: rtl/mux2_rr_arbiter_data_mux.sv
// DATA_WIDTH-bit 2:1 data mux assembled from single-bit mux cells.

// Single-bit 2:1 mux cell: sel=0 picks a, sel=1 picks b.
module mux2_cell (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic y
);

   // One bit of selection.
   assign y = sel ? b : a;

endmodule

// Bus-wide mux: one cell per data bit, all sharing the select line.
module arb_data_mux #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  sel,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] y
);

   // Replicate the bit cell across the bus.
   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      mux2_cell u_cell (
         .a   (a[i]),
         .b   (b[i]),
         .sel (sel),
         .y   (y[i])
      );
   end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter granting whole bursts from two requesters onto one
// valid/ready consumer through a shared registered-select data mux.
module mux2_rr_arbiter
   import mux2_rr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int MAX_BURST  = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ0,
   input  logic [DATA_WIDTH-1:0] D0,
   input  logic                  LAST0,
   output logic                  GNT0,
   input  logic                  REQ1,
   input  logic [DATA_WIDTH-1:0] D1,
   input  logic                  LAST1,
   output logic                  GNT1,
   output logic                  S,
   output logic                  VALID,
   output logic [DATA_WIDTH-1:0] Y,
   input  logic                  READY
);

   localparam int                CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);

   state_t                  state;
   state_t                  state_nxt;
   logic                    s_nxt;
   logic                    ptr;
   logic                    ptr_nxt;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_nxt;
   logic [DATA_WIDTH-1:0]   mux_y;

   logic                    own;
   logic                    req_own;
   logic                    last_own;
   logic                    req_oth;
   logic                    accept;
   logic                    release_own;
   logic                    burst_end;

   arb_data_mux #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mux (
      .sel (S),
      .a   (D0),
      .b   (D1),
      .y   (mux_y)
   );

   // State, select, round-robin pointer and beat counter; reset drops any burst.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         S     <= 1'b0;
         ptr   <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         S     <= s_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Grant decision, burst-end detection and handshake outputs.
   always_comb begin
      state_nxt   = state;
      s_nxt       = S;
      ptr_nxt     = ptr;
      cnt_nxt     = cnt;
      VALID       = 1'b0;
      Y           = '0;
      GNT0        = 1'b0;
      GNT1        = 1'b0;
      own         = 1'b0;
      req_own     = 1'b0;
      last_own    = 1'b0;
      req_oth     = 1'b0;
      accept      = 1'b0;
      release_own = 1'b0;
      burst_end   = 1'b0;

      case (state)
         IDLE: begin
            if (REQ0 || REQ1) begin
               // On a tie the requester not served last wins.
               own       = (REQ0 && REQ1) ? ~ptr : REQ1;
               state_nxt = own ? BUSY1 : BUSY0;
               s_nxt     = own;
               cnt_nxt   = '0;
            end
         end
         BUSY0, BUSY1: begin
            own         = (state == BUSY1);
            req_own     = own ? REQ1  : REQ0;
            last_own    = own ? LAST1 : LAST0;
            req_oth     = own ? REQ0  : REQ1;
            VALID       = req_own;
            Y           = mux_y;
            accept      = req_own & READY;
            GNT0        = accept & ~own;
            GNT1        = accept & own;
            release_own = ~req_own;
            burst_end   = release_own |
                          (accept & (last_own | ((cnt + 1'b1) == CNT_MAX)));
            if (burst_end) begin
               ptr_nxt = own;
               cnt_nxt = '0;
               if (req_oth) begin
                  state_nxt = own ? BUSY0 : BUSY1;
                  s_nxt     = ~own;
               end else if (!release_own) begin
                  state_nxt = state;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (accept) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
